// File: rtl/rs_multi.sv
// rs_multi: multi-entry reservation station between decode/rename and one
// execution unit.
//
// Holds DEPTH renamed instructions. Source operands come from the register
// file at dispatch, or later from NUM_WB wakeup/forward channels. Each cycle
// the oldest entry with both operands ready moves into a registered issue
// stage that ex can stall.
//
// Handshakes:
//   dispatch : a transfer happens on a rising edge where valid_id2rs=1,
//              full_rs2id=0 and flush_rob2rs=0. While full_rs2id=1, id must
//              hold its instruction, because a request into a full station
//              is dropped.
//   issue    : valid_rs2ex=1 presents one instruction to ex. When
//              stop_ex2rs=1, every issue output stays bit-stable and no
//              entry is released.
//
// Ports:
//   clk, res_n                      clock, asynchronous active-low reset
//   flush_rob2rs                    drop all entries and the issue register
//   opcode/funct3/imm_id2rs         decoded fields; valid_id2rs request
//   full_rs2id, count_rs2id         occupancy back to id
//   rs1/rs2/rd_rat2rs, tag_rob2rs   renamed tags and ROB tag
//   rs1/rs2_rf2rs (+ valid)         register file operand values
//   result/rd/valid_wb2rs           NUM_WB wakeup channels, packed by channel
//   stop_ex2rs                      ex stall
//   *_rs2ex, valid_rs2ex            registered issue stage
module rs_multi #(
    parameter int DEPTH  = 4,
    parameter int NUM_WB = 4,
    parameter int XLEN   = 64,
    parameter int PTAG_W = 6,
    parameter int ROB_W  = 6
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     flush_rob2rs,
    input  logic [6:0]               opcode_id2rs,
    input  logic [2:0]               funct3_id2rs,
    input  logic [11:0]              imm_id2rs,
    input  logic                     valid_id2rs,
    output logic                     full_rs2id,
    output logic [$clog2(DEPTH):0]   count_rs2id,
    input  logic [PTAG_W-1:0]        rs1_rat2rs,
    input  logic [PTAG_W-1:0]        rs2_rat2rs,
    input  logic [PTAG_W-1:0]        rd_rat2rs,
    input  logic [ROB_W-1:0]         tag_rob2rs,
    input  logic [XLEN-1:0]          rs1_rf2rs,
    input  logic                     valid_rs1_rf2rs,
    input  logic [XLEN-1:0]          rs2_rf2rs,
    input  logic                     valid_rs2_rf2rs,
    input  logic [NUM_WB*XLEN-1:0]   result_wb2rs,
    input  logic [NUM_WB*PTAG_W-1:0] rd_wb2rs,
    input  logic [NUM_WB-1:0]        valid_wb2rs,
    input  logic                     stop_ex2rs,
    output logic [6:0]               opcode_rs2ex,
    output logic [2:0]               funct3_rs2ex,
    output logic [ROB_W-1:0]         tag_rs2ex,
    output logic [XLEN-1:0]          rs1_rs2ex,
    output logic [XLEN-1:0]          rs2_rs2ex,
    output logic [PTAG_W-1:0]        rd_rs2ex,
    output logic [11:0]              imm_rs2ex,
    output logic                     valid_rs2ex
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    // Entry storage
    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  src1_rdy;
    logic [DEPTH-1:0]  src2_rdy;
    logic [6:0]        ent_opcode [DEPTH];
    logic [2:0]        ent_funct3 [DEPTH];
    logic [11:0]       ent_imm    [DEPTH];
    logic [PTAG_W-1:0] ent_rd     [DEPTH];
    logic [ROB_W-1:0]  ent_tag    [DEPTH];
    logic [PTAG_W-1:0] src1_tag   [DEPTH];
    logic [PTAG_W-1:0] src2_tag   [DEPTH];
    logic [XLEN-1:0]   src1_val   [DEPTH];
    logic [XLEN-1:0]   src2_val   [DEPTH];
    // Age matrix: older[i][j] = 1 means entry i was accepted before entry j.
    // Rows of invalid entries may hold stale bits. That is harmless because
    // only ready entries, which are always valid, take part in selection.
    logic [DEPTH-1:0]  older      [DEPTH];

    // Wakeup lookup: {hit, value} for the lowest-index valid channel whose
    // tag matches. The loop runs downwards so the lowest index wins.
    function automatic logic [XLEN:0] wb_lookup(input logic [PTAG_W-1:0] t);
        logic [XLEN:0] r;
        r = '0;
        for (int c = NUM_WB - 1; c >= 0; c--) begin
            if (valid_wb2rs[c] && (rd_wb2rs[c*PTAG_W +: PTAG_W] == t))
                r = {1'b1, result_wb2rs[c*XLEN +: XLEN]};
        end
        return r;
    endfunction

    logic [XLEN:0]     wake1 [DEPTH];
    logic [XLEN:0]     wake2 [DEPTH];
    logic [XLEN:0]     byp1;
    logic [XLEN:0]     byp2;
    logic              disp_r1;
    logic              disp_r2;
    logic [XLEN-1:0]   disp_v1;
    logic [XLEN-1:0]   disp_v2;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_found;
    logic              blocked;
    logic [DEPTH-1:0]  ent_ready;
    logic              disp_acc;
    logic              issue_fire;

    assign full_rs2id = (count_rs2id == CNT_W'(DEPTH));
    assign disp_acc   = valid_id2rs && !full_rs2id && !flush_rob2rs;
    assign issue_fire = sel_found && !stop_ex2rs && !flush_rob2rs;

    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        blocked   = 1'b0;
        ent_ready = ent_valid & src1_rdy & src2_rdy;

        // Lowest-index free slot. A free slot always exists when not full.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i])
                free_idx = IDX_W'(i);
        end

        // Oldest ready entry: no other ready entry is older than it.
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ent_ready[j] && older[j][i])
                    blocked = 1'b1;
            end
            if (ent_ready[i] && !blocked) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = wb_lookup(src1_tag[i]);
            wake2[i] = wb_lookup(src2_tag[i]);
        end

        // Dispatch capture priority: RF value, then same-cycle bypass, then wait.
        byp1    = wb_lookup(rs1_rat2rs);
        byp2    = wb_lookup(rs2_rat2rs);
        disp_r1 = valid_rs1_rf2rs || byp1[XLEN];
        disp_r2 = valid_rs2_rf2rs || byp2[XLEN];
        disp_v1 = valid_rs1_rf2rs ? rs1_rf2rs : byp1[XLEN-1:0];
        disp_v2 = valid_rs2_rf2rs ? rs2_rf2rs : byp2[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ent_valid    <= '0;
            src1_rdy     <= '0;
            src2_rdy     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_opcode[i] <= '0;
                ent_funct3[i] <= '0;
                ent_imm[i]    <= '0;
                ent_rd[i]     <= '0;
                ent_tag[i]    <= '0;
                src1_tag[i]   <= '0;
                src2_tag[i]   <= '0;
                src1_val[i]   <= '0;
                src2_val[i]   <= '0;
                older[i]      <= '0;
            end
            count_rs2id  <= '0;
            opcode_rs2ex <= '0;
            funct3_rs2ex <= '0;
            tag_rs2ex    <= '0;
            rs1_rs2ex    <= '0;
            rs2_rs2ex    <= '0;
            rd_rs2ex     <= '0;
            imm_rs2ex    <= '0;
            valid_rs2ex  <= 1'b0;
        end else if (flush_rob2rs) begin
            // Flush wins over the stall. Payload registers keep their old
            // contents; only valids and occupancy matter.
            ent_valid   <= '0;
            count_rs2id <= '0;
            valid_rs2ex <= 1'b0;
        end else begin
            // Wakeup of waiting sources in occupied entries
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid[i] && !src1_rdy[i] && wake1[i][XLEN]) begin
                    src1_rdy[i] <= 1'b1;
                    src1_val[i] <= wake1[i][XLEN-1:0];
                end
                if (ent_valid[i] && !src2_rdy[i] && wake2[i][XLEN]) begin
                    src2_rdy[i] <= 1'b1;
                    src2_val[i] <= wake2[i][XLEN-1:0];
                end
            end

            // Issue stage
            if (!stop_ex2rs) begin
                valid_rs2ex <= sel_found;
                if (sel_found) begin
                    opcode_rs2ex <= ent_opcode[sel_idx];
                    funct3_rs2ex <= ent_funct3[sel_idx];
                    tag_rs2ex    <= ent_tag[sel_idx];
                    rs1_rs2ex    <= src1_val[sel_idx];
                    rs2_rs2ex    <= src2_val[sel_idx];
                    rd_rs2ex     <= ent_rd[sel_idx];
                    imm_rs2ex    <= ent_imm[sel_idx];
                    ent_valid[sel_idx] <= 1'b0;
                end
            end

            // Dispatch into the free slot. The slot was invalid, so the
            // wakeup and issue writes above never touch it.
            if (disp_acc) begin
                ent_valid[free_idx]  <= 1'b1;
                ent_opcode[free_idx] <= opcode_id2rs;
                ent_funct3[free_idx] <= funct3_id2rs;
                ent_imm[free_idx]    <= imm_id2rs;
                ent_rd[free_idx]     <= rd_rat2rs;
                ent_tag[free_idx]    <= tag_rob2rs;
                src1_tag[free_idx]   <= rs1_rat2rs;
                src2_tag[free_idx]   <= rs2_rat2rs;
                src1_rdy[free_idx]   <= disp_r1;
                src2_rdy[free_idx]   <= disp_r2;
                src1_val[free_idx]   <= disp_v1;
                src2_val[free_idx]   <= disp_v2;
                // The new entry is younger than every entry already present.
                older[free_idx]      <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != int'(free_idx))
                        older[j][free_idx] <= ent_valid[j];
                end
            end

            count_rs2id <= count_rs2id + CNT_W'(disp_acc) - CNT_W'(issue_fire);
        end
    end

endmodule
